// File: rtl/key_event_queue.sv
`default_nettype none
// ============================================================================
//  Module      : key_event_queue
//  Description : Push-button conditioning for the river-crossing game.
//                Four raw buttons are synchronized, debounced and turned
//                into single press events. The events are delivered one at
//                a time through a valid/ack handshake. Clocked at 1 kHz, so
//                one cycle is one millisecond.
//                Optional feature macro: KEY_AUTOREPEAT_EN adds hold-to-repeat.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_event_queue #(
  parameter int DEBOUNCE_MS = 20,
  parameter int HOLD_MS     = 500,
  parameter int REPEAT_MS   = 250
) (
  input  logic       clk_1kHz,
  input  logic       rst_n,
  input  logic       btn_7,
  input  logic       btn_6,
  input  logic       btn_5,
  input  logic       btn_4,
  input  logic       key_ack,
  output logic       key_valid,
  output logic [1:0] key_code,
  output logic [3:0] key_level,
  output logic       key_drop
);

  localparam int                 c_CNT_W   = $clog2(DEBOUNCE_MS + 1);
  // The level flips on the edge at which the count would reach DEBOUNCE_MS.
  localparam logic [c_CNT_W-1:0] c_DB_LAST = c_CNT_W'(DEBOUNCE_MS - 1);

  localparam logic [0:0] c_ST_EMPTY = 1'b0;
  localparam logic [0:0] c_ST_FULL  = 1'b1;

  logic [3:0] w_raw;
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [3:0] w_level;
  logic [3:0] w_press;
  logic [3:0] w_rep;
  logic [3:0] w_req;
  logic [1:0] w_win_code;
  logic       w_multi;

  logic [0:0] r_state;
  logic [0:0] w_state_nxt;
  logic [1:0] r_code;
  logic [1:0] w_code_nxt;
  logic       r_drop;
  logic       w_drop;

  assign w_raw = {btn_7, btn_6, btn_5, btn_4};

  // Two-flop synchronizer for all four raw buttons.
  always_ff @(posedge clk_1kHz or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 4'b0000;
      r_sync2 <= 4'b0000;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_chan
      logic [c_CNT_W-1:0] r_db_cnt;
      logic               r_lvl;
      logic               r_lvl_d;
      logic               w_press_i;

      // Debounce: count disagreement cycles, flip the level once it persists.
      always_ff @(posedge clk_1kHz or negedge rst_n) begin
        if (!rst_n) begin
          r_db_cnt <= '0;
          r_lvl    <= 1'b0;
        end else if (r_sync2[gi] != r_lvl) begin
          if (r_db_cnt == c_DB_LAST) begin
            r_lvl    <= ~r_lvl;
            r_db_cnt <= '0;
          end else begin
            r_db_cnt <= r_db_cnt + c_CNT_W'(1);
          end
        end else begin
          r_db_cnt <= '0;
        end
      end

      // Delayed level, used to spot the 0->1 transition.
      always_ff @(posedge clk_1kHz or negedge rst_n) begin
        if (!rst_n) begin
          r_lvl_d <= 1'b0;
        end else begin
          r_lvl_d <= r_lvl;
        end
      end

      assign w_press_i   = r_lvl & ~r_lvl_d;
      assign w_press[gi] = w_press_i;
      assign w_level[gi] = r_lvl;

`ifdef KEY_AUTOREPEAT_EN
      localparam int                 c_RPT_MAX   = (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
      localparam int                 c_RPT_W     = $clog2(c_RPT_MAX + 1);
      localparam logic [c_RPT_W-1:0] c_HOLD_LAST = c_RPT_W'(HOLD_MS - 1);
      localparam logic [c_RPT_W-1:0] c_REP_LAST  = c_RPT_W'(REPEAT_MS - 1);

      logic [c_RPT_W-1:0] r_rpt_cnt;
      logic               r_rpt_phase;   // 0: waiting for hold, 1: repeating
      logic               w_rpt_hit;

      assign w_rpt_hit = r_lvl & ~w_press_i &
                         (r_rpt_cnt == (r_rpt_phase ? c_REP_LAST : c_HOLD_LAST));
      assign w_rep[gi] = w_rpt_hit;

      // Repeat timer: restarts on press, idles while released, reloads on each hit.
      always_ff @(posedge clk_1kHz or negedge rst_n) begin
        if (!rst_n) begin
          r_rpt_cnt   <= '0;
          r_rpt_phase <= 1'b0;
        end else if (!r_lvl || w_press_i) begin
          r_rpt_cnt   <= '0;
          r_rpt_phase <= 1'b0;
        end else if (w_rpt_hit) begin
          r_rpt_cnt   <= '0;
          r_rpt_phase <= 1'b1;
        end else begin
          r_rpt_cnt   <= r_rpt_cnt + c_RPT_W'(1);
        end
      end
`else
      assign w_rep[gi] = 1'b0;
`endif
    end
  endgenerate

`ifndef KEY_AUTOREPEAT_EN
  // Repeat timing parameters only matter when the repeat logic is built.
  logic w_unused_cfg;
  assign w_unused_cfg = (HOLD_MS != REPEAT_MS);
`endif

  assign w_req = w_press | w_rep;

  // Fixed priority: higher code wins, any additional request is a loser.
  always_comb begin
    w_win_code = 2'd0;
    if (w_req[3]) begin
      w_win_code = 2'd3;
    end else if (w_req[2]) begin
      w_win_code = 2'd2;
    end else if (w_req[1]) begin
      w_win_code = 2'd1;
    end
    w_multi = |(w_req & (w_req - 4'd1));
  end

  // Single-entry event register with drop detection.
  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_drop      = 1'b0;
    case (r_state)
      c_ST_EMPTY: begin
        if (|w_req) begin
          w_state_nxt = c_ST_FULL;
          w_code_nxt  = w_win_code;
          w_drop      = w_multi;
        end
      end
      default: begin
        if (key_ack) begin
          if (|w_req) begin
            w_code_nxt = w_win_code;
            w_drop     = w_multi;
          end else begin
            w_state_nxt = c_ST_EMPTY;
          end
        end else begin
          w_drop = |w_req;
        end
      end
    endcase
  end

  // Event register, code and registered drop pulse.
  always_ff @(posedge clk_1kHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_EMPTY;
      r_code  <= 2'd0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_code  <= w_code_nxt;
      r_drop  <= w_drop;
    end
  end

  assign key_valid = (r_state == c_ST_FULL);
  assign key_code  = r_code;
  assign key_level = w_level;
  assign key_drop  = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_key_event_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_event_queue
//  Description : Self-checking bench for key_event_queue. Expected event codes
//                are queued when buttons are driven and popped on acceptance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_event_queue;

  localparam int c_D = 20;

  logic       clk_1kHz = 1'b0;
  logic       rst_n    = 1'b0;
  logic       btn_7    = 1'b0;
  logic       btn_6    = 1'b0;
  logic       btn_5    = 1'b0;
  logic       btn_4    = 1'b0;
  logic       key_ack  = 1'b0;
  logic       key_valid;
  logic [1:0] key_code;
  logic [3:0] key_level;
  logic       key_drop;

  int n_checks = 0;
  int n_fail   = 0;
  int n_drops  = 0;
  int cyc      = 0;
  int q_exp[$];

  key_event_queue #(
    .DEBOUNCE_MS(c_D),
    .HOLD_MS    (500),
    .REPEAT_MS  (250)
  ) u_dut (
    .clk_1kHz (clk_1kHz),
    .rst_n    (rst_n),
    .btn_7    (btn_7),
    .btn_6    (btn_6),
    .btn_5    (btn_5),
    .btn_4    (btn_4),
    .key_ack  (key_ack),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_level(key_level),
    .key_drop (key_drop)
  );

  always #5 clk_1kHz = ~clk_1kHz;

  // Cycle count and drop-pulse count, sampled on the inactive edge.
  always @(negedge clk_1kHz) begin
    cyc++;
    if (key_drop) n_drops++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag, input int budget, output int n);
    n = 0;
    while (!key_valid && n < budget) begin
      @(negedge clk_1kHz);
      n++;
    end
    if (!key_valid) check({tag, "_timeout"}, 0, 1);
  endtask

  // Pop the scoreboard, compare the pending code and ack for one cycle.
  task automatic accept(input string tag);
    logic [31:0] exp;
    if (q_exp.size() == 0) exp = 32'hFFFF_FFFF;
    else exp = q_exp.pop_front();
    check(tag, key_code, exp);
    key_ack = 1'b1;
    @(negedge clk_1kHz);
    key_ack = 1'b0;
  endtask

  task automatic latency(input string tag, input int bit_idx);
    int lvl_t;
    int val_t;
    lvl_t = 0;
    val_t = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk_1kHz);
      if (key_level[bit_idx] && lvl_t == 0) lvl_t = i;
      if (key_valid) begin
        val_t = i;
        break;
      end
    end
    check({tag, "_level_lat"}, lvl_t, c_D + 2);
    check({tag, "_valid_lat"}, val_t, c_D + 3);
  endtask

  initial begin
    int n;
    int d0;
    int seen;
    int t0;
    int times[$];
    int exp_times[$];

    // Reset state
    repeat (3) @(negedge clk_1kHz);
    check("rst_valid", key_valid, 0);
    check("rst_code",  key_code,  0);
    check("rst_level", key_level, 0);
    check("rst_drop",  key_drop,  0);
    rst_n = 1'b1;
    @(negedge clk_1kHz);

    // Held btn_6: latency, level, single event
    d0 = n_drops;
    btn_6 = 1'b1;
    latency("t1", 2);
    check("t1_level", key_level, 4'b0100);
    q_exp.push_back(2);
    accept("t1_code");
    check("t1_valid_after_ack", key_valid, 0);
    seen = 0;
    repeat (60) begin
      @(negedge clk_1kHz);
      if (key_valid) seen = 1;
    end
    check("t1_no_second_event", seen, 0);
    btn_6 = 1'b0;
    repeat (c_D + 5) @(negedge clk_1kHz);
    check("t1_release_level", key_level, 0);
    check("t1_drops", n_drops - d0, 0);

    // Short glitch on btn_5
    d0 = n_drops;
    seen = 0;
    for (int i = 0; i < 15 + c_D + 10; i++) begin
      btn_5 = (i < 15);
      @(negedge clk_1kHz);
      if (key_valid || key_level != 4'b0000) seen = 1;
    end
    check("t2_glitch_seen", seen, 0);
    check("t2_drops", n_drops - d0, 0);

    // Simultaneous btn_7 and btn_4
    d0 = n_drops;
    btn_7 = 1'b1;
    btn_4 = 1'b1;
    q_exp.push_back(3);
    wait_valid("t3", 60, n);
    accept("t3_code");
    repeat (5) @(negedge clk_1kHz);
    check("t3_no_loser_event", key_valid, 0);
    check("t3_drops", n_drops - d0, 1);
    btn_7 = 1'b0;
    btn_4 = 1'b0;
    repeat (c_D + 5) @(negedge clk_1kHz);

    // Pending event, no ack, btn_5 dropped; then ack collides with btn_4
    d0 = n_drops;
    btn_6 = 1'b1;
    q_exp.push_back(2);
    wait_valid("t4", 60, n);
    btn_5 = 1'b1;
    repeat (c_D + 6) @(negedge clk_1kHz);
    check("t4_held_code",  key_code,  2);
    check("t4_held_valid", key_valid, 1);
    check("t4_drops", n_drops - d0, 1);
    btn_4 = 1'b1;
    n = 0;
    while (!key_level[0] && n < 60) begin
      @(negedge clk_1kHz);
      n++;
    end
    if (!key_level[0]) check("t4_level_timeout", 0, 1);
    accept("t4_code_first");
    q_exp.push_back(0);
    check("t4_reload_valid", key_valid, 1);
    check("t4_reload_code",  key_code,  0);
    accept("t4_code_second");
    check("t4_drops_after", n_drops - d0, 1);
    btn_6 = 1'b0;
    btn_5 = 1'b0;
    btn_4 = 1'b0;
    repeat (c_D + 5) @(negedge clk_1kHz);
    check("t4_idle_valid", key_valid, 0);

    // Reset while an event is pending and btn_6 held
    btn_6 = 1'b1;
    wait_valid("t5", 60, n);
    check("t5_pre_code", key_code, 2);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", key_valid, 0);
    check("t5_rst_level", key_level, 0);
    check("t5_rst_code",  key_code,  0);
    repeat (2) @(negedge clk_1kHz);
    rst_n = 1'b1;
    latency("t5", 2);
    q_exp.push_back(2);
    accept("t5_code");
    btn_6 = 1'b0;
    repeat (c_D + 5) @(negedge clk_1kHz);

    // Held btn_4 with immediate acks: autorepeat schedule
`ifdef KEY_AUTOREPEAT_EN
    exp_times = '{0, 500, 750, 1000};
`else
    exp_times = '{0};
`endif
    btn_4 = 1'b1;
    wait_valid("t6", 60, n);
    t0 = cyc;
    for (int i = 0; i < 1220; i++) begin
      if (key_valid && !key_ack) begin
        times.push_back(cyc - t0);
        check("t6_code", key_code, 0);
        key_ack = 1'b1;
      end else begin
        key_ack = 1'b0;
      end
      @(negedge clk_1kHz);
    end
    key_ack = 1'b0;
    check("t6_event_count", times.size(), exp_times.size());
    for (int i = 0; i < exp_times.size() && i < times.size(); i++) begin
      check($sformatf("t6_time%0d", i), times[i], exp_times[i]);
    end
    btn_4 = 1'b0;
    repeat (c_D + 5) @(negedge clk_1kHz);
    check("t6_release_level", key_level, 0);

    check("sb_empty", q_exp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_event_queue.md
# key_event_queue

Input-conditioning stage for the cat/dog/mouse river-crossing game. It converts the four raw push-buttons into debounced levels and single press events, one at a time. The game/scanning logic consumes these events through a valid/ack handshake. It runs in the 1 kHz domain, so every cycle is 1 ms.

## Interface
Parameters:
- DEBOUNCE_MS, 20: consecutive cycles a synchronized input must disagree with the debounced level before that level flips.
- HOLD_MS, 500: held cycles before the first autorepeat. Used only with KEY_AUTOREPEAT_EN.
- REPEAT_MS, 250: cycles between autorepeats. Used only with KEY_AUTOREPEAT_EN.

Ports:
- clk_1kHz  in  1  system clock, 1 kHz.
- rst_n  in  1  asynchronous active-low reset.
- btn_7  in  1  cat button, raw, active-high.
- btn_6  in  1  dog button, raw, active-high.
- btn_5  in  1  mouse button, raw, active-high.
- btn_4  in  1  canoe button, raw, active-high.
- key_ack  in  1  consumer accepts the pending event.
- key_valid  out  1  event pending.
- key_code  out  2  pending event: 3 = btn_7, 2 = btn_6, 1 = btn_5, 0 = btn_4.
- key_level  out  4  debounced levels, {btn_7, btn_6, btn_5, btn_4}.
- key_drop  out  1  one-cycle pulse: one or more press events were discarded this cycle.

## Operation
Reset:
- While rst_n = 0, all outputs are 0.
- Synchronizers, debounce counters, debounced levels, the event register and the repeat counters are all cleared.
- Reset asserted mid-debounce or with an event pending discards everything.
- After release, a button already held is seen as a new press once it has been stable for DEBOUNCE_MS cycles.

Per channel:
- Two-flop synchronizer.
- Debounce counter, width $clog2(DEBOUNCE_MS+1). It counts while the synced input differs from the debounced level and clears to 0 whenever they agree.
- When the count reaches DEBOUNCE_MS, the level toggles and the counter clears.
- A glitch shorter than DEBOUNCE_MS cycles never changes the level.
- A 0→1 level transition raises a press request for one cycle. A 1→0 transition raises no event.

Arbitration and event register:
- Simultaneous requests: the highest code wins (3 > 2 > 1 > 0). All losers are dropped and key_drop pulses.
- The event register has two states, EMPTY and FULL.
  - EMPTY plus a request: load key_code, set key_valid, go to FULL.
  - FULL plus key_ack: clear key_valid, go to EMPTY. If a request arrives in that same cycle, load it instead and stay FULL.
  - FULL without key_ack: key_code is held stable. Any new request is dropped and key_drop pulses.
- key_ack while EMPTY is ignored.
- key_level is a direct register output, independent of the handshake.

## Timing
- A raw button rising before edge 0 and held: synced high after edge 1, key_level bit high after edge 1+DEBOUNCE_MS, key_valid high after edge 2+DEBOUNCE_MS. Total latency is DEBOUNCE_MS+2 cycles.
- Release is seen on key_level after the same DEBOUNCE_MS+1 cycles.
- Handshake: when key_valid = 1 and key_ack = 1 at edge n, key_valid is 0 after edge n (or reloaded, per the rules above). Minimum throughput is one event per 2 cycles if the consumer acks immediately.
- key_drop is a registered pulse, asserted the cycle after the edge where the drop occurred.

## Configuration
- KEY_AUTOREPEAT_EN defined:
  - Each channel gets a repeat counter, width $clog2(max(HOLD_MS,REPEAT_MS)+1).
  - The counter is cleared by the press transition and while the level is 0.
  - While the level stays 1, it raises a repeat request HOLD_MS cycles after the press, then every REPEAT_MS cycles.
  - Repeat requests enter the same arbitration and drop rules as fresh presses.
- KEY_AUTOREPEAT_EN undefined: no repeat logic is instantiated, HOLD_MS and REPEAT_MS are unused, and a held key produces exactly one event.

## Test plan
- Reset, then btn_6 held high continuously → key_level = 4'b0100 and key_valid = 1 with key_code = 2 exactly 22 cycles after sync (DEBOUNCE_MS = 20). Ack → key_valid = 0 and no further event.
- btn_5 high for 15 cycles, then low → key_level and key_valid stay 0 and key_drop stays 0.
- btn_7 and btn_4 rise in the same cycle → key_code = 3 and key_drop pulses once. btn_4's press is lost.
- Event pending, no ack, then btn_5 pressed → key_code unchanged and key_drop pulses once. Ack in the same cycle as a new btn_4 request → key_valid stays 1 and key_code becomes 0.
- rst_n pulsed low while key_valid = 1 and btn_6 held → outputs clear immediately. After release, a fresh event with key_code = 2 appears DEBOUNCE_MS+2 cycles later.
- With KEY_AUTOREPEAT_EN, btn_4 held for 1200 cycles after debounce and every event acked → events at t = 0, 500, 750, 1000. Without the macro → only t = 0.
